// File: rtl/ballot_box_tally.sv
// ballot_box_tally
//   Counts the avatar-election controller's per-cycle results for each ballot
//   box. Three counts are kept per box: accepted registrations, accepted votes
//   and rejected requests. When the election closes, one summary record per box
//   is streamed out over a valid/ready handshake.
//
// Ports
//   CLK, RST_N             clock (rising edge), asynchronous active-low reset
//   op_valid               controller produced a result this cycle
//   mode                   00 register, 01 vote, 10/11 ignored
//   ballot_box_id          box of the processed user
//   already_registered,
//   already_voted,
//   not_registered,
//   voting_not_started,
//   registration_ended     rejection flags; any one set marks the op rejected
//   election_done          level; closes counting and starts the report
//   report_valid/ready     record handshake
//   report_box/regs/votes/errors, report_full_turnout   current record
//   tally_done             every record has been accepted
module ballot_box_tally #(
  parameter int NUM_BOXES = 4,
  parameter int CNT_W     = 5,
  parameter int ERR_W     = 8,
  localparam int BOX_W    = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             op_valid,
  input  logic [1:0]       mode,
  input  logic [BOX_W-1:0] ballot_box_id,
  input  logic             already_registered,
  input  logic             already_voted,
  input  logic             not_registered,
  input  logic             voting_not_started,
  input  logic             registration_ended,
  input  logic             election_done,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [BOX_W-1:0] report_box,
  output logic [CNT_W-1:0] report_regs,
  output logic [CNT_W-1:0] report_votes,
  output logic [ERR_W-1:0] report_errors,
  output logic             report_full_turnout,
  output logic             tally_done
);

  typedef enum logic [1:0] {COLLECT, REPORT, DONE} state_t;

  localparam logic [BOX_W-1:0] LAST_BOX = BOX_W'(NUM_BOXES - 1);

  state_t           state;
  logic [BOX_W-1:0] ptr;

  logic [CNT_W-1:0] cnt_regs  [NUM_BOXES];
  logic [CNT_W-1:0] cnt_votes [NUM_BOXES];
  logic [ERR_W-1:0] cnt_errs  [NUM_BOXES];

  logic err;
  logic count_en;
  logic show;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign err = already_registered | already_voted | not_registered |
               voting_not_started | registration_ended;

  // Only register/vote modes touch the counters, and only while collecting.
  // The op in the closing cycle is still counted since state is COLLECT.
  assign count_en = (state == COLLECT) && op_valid && !mode[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        cnt_regs[i]  <= '0;
        cnt_votes[i] <= '0;
        cnt_errs[i]  <= '0;
      end
    end else if (count_en) begin
      if (err)
        cnt_errs[ballot_box_id] <= sat_inc_err(cnt_errs[ballot_box_id]);
      else if (mode[0])
        cnt_votes[ballot_box_id] <= sat_inc_cnt(cnt_votes[ballot_box_id]);
      else
        cnt_regs[ballot_box_id] <= sat_inc_cnt(cnt_regs[ballot_box_id]);
    end
  end

  // Control FSM. report_valid is high for the whole of REPORT, so an edge
  // with report_ready high is a handshake there.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= COLLECT;
      ptr          <= '0;
      report_valid <= 1'b0;
      tally_done   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (election_done) begin
            state        <= REPORT;
            report_valid <= 1'b1;
          end
        end
        REPORT: begin
          if (report_ready) begin
            if (ptr == LAST_BOX) begin
              state        <= DONE;
              report_valid <= 1'b0;
              tally_done   <= 1'b1;
            end else begin
              ptr <= ptr + BOX_W'(1);
            end
          end
        end
        DONE: begin
          // Terminal until reset; ptr stays on the last box so the final
          // record remains on the data outputs.
        end
        default: begin
          state        <= COLLECT;
          report_valid <= 1'b0;
          tally_done   <= 1'b0;
        end
      endcase
    end
  end

  // Record fields read zero while collecting; ptr is still 0 then.
  assign show          = (state != COLLECT);
  assign report_box    = ptr;
  assign report_regs   = show ? cnt_regs[ptr]  : '0;
  assign report_votes  = show ? cnt_votes[ptr] : '0;
  assign report_errors = show ? cnt_errs[ptr]  : '0;

  assign report_full_turnout = (report_votes == report_regs) && (report_regs != '0);

endmodule

// File: tb/tb_ballot_box_tally.sv
module tb_ballot_box_tally;

  localparam int NB      = 4;
  localparam int CW      = 5;
  localparam int EW      = 8;
  localparam int SAT_CNT = (1 << CW) - 1;
  localparam int SAT_ERR = (1 << EW) - 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          op_valid = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [1:0]    ballot_box_id = 2'b00;
  logic          already_registered = 1'b0;
  logic          already_voted = 1'b0;
  logic          not_registered = 1'b0;
  logic          voting_not_started = 1'b0;
  logic          registration_ended = 1'b0;
  logic          election_done = 1'b0;
  logic          report_valid;
  logic          report_ready = 1'b0;
  logic [1:0]    report_box;
  logic [CW-1:0] report_regs;
  logic [CW-1:0] report_votes;
  logic [EW-1:0] report_errors;
  logic          report_full_turnout;
  logic          tally_done;

  always #5 CLK = ~CLK;

  ballot_box_tally #(.NUM_BOXES(NB), .CNT_W(CW), .ERR_W(EW)) dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .op_valid            (op_valid),
    .mode                (mode),
    .ballot_box_id       (ballot_box_id),
    .already_registered  (already_registered),
    .already_voted       (already_voted),
    .not_registered      (not_registered),
    .voting_not_started  (voting_not_started),
    .registration_ended  (registration_ended),
    .election_done       (election_done),
    .report_valid        (report_valid),
    .report_ready        (report_ready),
    .report_box          (report_box),
    .report_regs         (report_regs),
    .report_votes        (report_votes),
    .report_errors       (report_errors),
    .report_full_turnout (report_full_turnout),
    .tally_done          (tally_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain per-box tallies.
  int m_regs  [NB];
  int m_votes [NB];
  int m_errs  [NB];

  typedef struct {
    logic [1:0] md;
    int         bx;
    logic [4:0] fl;   // {already_reg, already_voted, not_reg, voting_not_started, reg_ended}
  } op_vec_t;

  typedef struct {
    int box;
    int regs;
    int votes;
    int errs;
    int ft;
  } rec_t;

  op_vec_t ops_tbl [8];
  rec_t    exp_tbl [4];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) begin
      m_regs[i] = 0; m_votes[i] = 0; m_errs[i] = 0;
    end
  endtask

  task automatic model_op(input logic [1:0] md, input int bx, input logic [4:0] fl);
    if (md == 2'b00 || md == 2'b01) begin
      if (fl != 5'd0)        m_errs[bx]  = (m_errs[bx]  < SAT_ERR) ? m_errs[bx] + 1  : SAT_ERR;
      else if (md == 2'b00)  m_regs[bx]  = (m_regs[bx]  < SAT_CNT) ? m_regs[bx] + 1  : SAT_CNT;
      else                   m_votes[bx] = (m_votes[bx] < SAT_CNT) ? m_votes[bx] + 1 : SAT_CNT;
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] md, input int bx, input logic [4:0] fl);
    op_valid           = v;
    mode               = md;
    ballot_box_id      = 2'(bx);
    already_registered = fl[4];
    already_voted      = fl[3];
    not_registered     = fl[2];
    voting_not_started = fl[1];
    registration_ended = fl[0];
  endtask

  task automatic op(input logic [1:0] md, input int bx, input logic [4:0] fl);
    drive(1'b1, md, bx, fl);
    model_op(md, bx, fl);
    @(posedge CLK); #1;
    drive(1'b0, 2'b00, 0, 5'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, report_valid, 0);
    chk({tag, " tally_done"}, tally_done, 0);
    chk({tag, " box"}, report_box, 0);
    chk({tag, " regs"}, report_regs, 0);
    chk({tag, " votes"}, report_votes, 0);
    chk({tag, " errors"}, report_errors, 0);
    chk({tag, " ft"}, report_full_turnout, 0);
  endtask

  task automatic do_reset(input string tag);
    RST_N = 1'b0;
    election_done = 1'b0;
    report_ready = 1'b0;
    drive(1'b0, 2'b00, 0, 5'd0);
    model_clear();
    #2;
    chk_idle({tag, " reset"});
    @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  task automatic close_election();
    election_done = 1'b1;
    @(posedge CLK); #1;
    election_done = 1'b0;
  endtask

  // Consume all records, checking each against the model every cycle it is
  // presented (stalled cycles included, which also checks stability).
  task automatic drain(input bit rand_ready, input string tag);
    int b = 0;
    int cyc = 0;
    int ft;
    while (b < NB && cyc < 200) begin
      report_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ft = (m_votes[b] == m_regs[b] && m_regs[b] != 0) ? 1 : 0;
      chk($sformatf("%s rec%0d valid", tag, b), report_valid, 1);
      chk($sformatf("%s rec%0d box", tag, b), report_box, b);
      chk($sformatf("%s rec%0d regs", tag, b), report_regs, m_regs[b]);
      chk($sformatf("%s rec%0d votes", tag, b), report_votes, m_votes[b]);
      chk($sformatf("%s rec%0d errors", tag, b), report_errors, m_errs[b]);
      chk($sformatf("%s rec%0d ft", tag, b), report_full_turnout, ft);
      @(posedge CLK); #1;
      cyc++;
      if (report_ready) b++;
    end
    report_ready = 1'b0;
    chk({tag, " drain within budget"}, b, NB);
    chk({tag, " valid after last"}, report_valid, 0);
    chk({tag, " tally_done after last"}, tally_done, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ops_tbl[0] = '{2'b00, 2, 5'b00000};
    ops_tbl[1] = '{2'b00, 2, 5'b00000};
    ops_tbl[2] = '{2'b00, 2, 5'b00000};
    ops_tbl[3] = '{2'b01, 2, 5'b00000};
    ops_tbl[4] = '{2'b00, 1, 5'b10000};
    ops_tbl[5] = '{2'b01, 1, 5'b00100};
    ops_tbl[6] = '{2'b01, 3, 5'b00010};
    ops_tbl[7] = '{2'b10, 0, 5'b00000};
    exp_tbl[0] = '{0, 0, 0, 0, 0};
    exp_tbl[1] = '{1, 0, 0, 2, 0};
    exp_tbl[2] = '{2, 3, 1, 0, 0};
    exp_tbl[3] = '{3, 0, 0, 1, 0};

    #1;
    // Basic counting and mixed rejections, table-driven.
    do_reset("t1");
    for (int i = 0; i < 8; i++) op(ops_tbl[i].md, ops_tbl[i].bx, ops_tbl[i].fl);
    report_ready = 1'b1;
    close_election();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1 rec%0d valid", i), report_valid, 1);
      chk($sformatf("t1 rec%0d box", i), report_box, exp_tbl[i].box);
      chk($sformatf("t1 rec%0d regs", i), report_regs, exp_tbl[i].regs);
      chk($sformatf("t1 rec%0d votes", i), report_votes, exp_tbl[i].votes);
      chk($sformatf("t1 rec%0d errors", i), report_errors, exp_tbl[i].errs);
      chk($sformatf("t1 rec%0d ft", i), report_full_turnout, exp_tbl[i].ft);
      @(posedge CLK); #1;
    end
    report_ready = 1'b0;
    chk("t1 done valid", report_valid, 0);
    chk("t1 tally_done", tally_done, 1);
    // DONE ignores further ops and holds the last record.
    op(2'b00, 3, 5'd0);
    election_done = 1'b1;
    op(2'b01, 3, 5'd1);
    election_done = 1'b0;
    @(posedge CLK); #1;
    chk("t1 hold tally_done", tally_done, 1);
    chk("t1 hold valid", report_valid, 0);
    chk("t1 hold box", report_box, 3);
    chk("t1 hold regs", report_regs, 0);
    chk("t1 hold errors", report_errors, 1);

    // Full turnout with a 3-cycle stall.
    do_reset("t3");
    op(2'b00, 0, 5'd0);
    op(2'b00, 0, 5'd0);
    op(2'b01, 0, 5'd0);
    op(2'b01, 0, 5'd0);
    chk("t3 collect valid", report_valid, 0);
    chk("t3 collect regs hidden", report_regs, 0);
    chk("t3 collect ft", report_full_turnout, 0);
    report_ready = 1'b0;
    close_election();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t3 stall%0d valid", k), report_valid, 1);
      chk($sformatf("t3 stall%0d box", k), report_box, 0);
      chk($sformatf("t3 stall%0d regs", k), report_regs, 2);
      chk($sformatf("t3 stall%0d votes", k), report_votes, 2);
      chk($sformatf("t3 stall%0d errors", k), report_errors, 0);
      chk($sformatf("t3 stall%0d ft", k), report_full_turnout, 1);
      @(posedge CLK); #1;
    end
    drain(1'b0, "t3");

    // Saturation on box 3.
    do_reset("t4");
    for (int i = 0; i < 40; i++) op(2'b00, 3, 5'd0);
    for (int i = 0; i < 300; i++) op(2'($urandom_range(0, 1)), 3, 5'($urandom_range(1, 31)));
    close_election();
    drain(1'b1, "t4");
    chk("t4 sat regs", report_regs, 31);
    chk("t4 sat errors", report_errors, 255);
    chk("t4 sat votes", report_votes, 0);

    // Same-cycle close: the coincident vote counts, the next op does not.
    do_reset("t5");
    report_ready = 1'b0;
    drive(1'b1, 2'b01, 1, 5'd0);
    model_op(2'b01, 1, 5'd0);
    election_done = 1'b1;
    @(posedge CLK); #1;
    election_done = 1'b0;
    drive(1'b1, 2'b01, 1, 5'd0);
    @(posedge CLK); #1;
    drive(1'b1, 2'b00, 2, 5'd0);
    @(posedge CLK); #1;
    drive(1'b0, 2'b00, 0, 5'd0);
    drain(1'b0, "t5");
    chk("t5 last box regs", report_regs, 0);

    // Reset in the middle of the report.
    do_reset("t6");
    op(2'b00, 0, 5'd0);
    op(2'b00, 1, 5'd0);
    op(2'b01, 1, 5'd0);
    op(2'b01, 2, 5'd4);
    report_ready = 1'b1;
    close_election();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("t6 box before reset", report_box, 2);
    chk("t6 errors before reset", report_errors, 1);
    do_reset("t6 mid");
    close_election();
    drain(1'b0, "t6 after");

    // Randomized elections against the model.
    for (int r = 0; r < 3; r++) begin
      do_reset($sformatf("r%0d", r));
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          op(2'($urandom_range(0, 3)), int'($urandom_range(0, NB - 1)),
             ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
        end else begin
          @(posedge CLK); #1;
        end
      end
      close_election();
      drain(1'b1, $sformatf("r%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ballot_box_tally.md
Name: ballot_box_tally

Overview:
- Downstream consumer of the avatar-election controller's per-cycle outputs (ballotBoxId plus status flags).
- Keeps per-ballot-box counts of accepted registrations, accepted votes and rejected requests.
- When the election closes, streams one summary record per box over a valid/ready handshake to the results display/UART stage.

Parameters:
NUM_BOXES, 4, number of ballot boxes; box index width BOX_W = clog2(NUM_BOXES), 2 at default
CNT_W, 5, width of per-box registration and vote counters (16 voters per box, margin to 31)
ERR_W, 8, width of per-box rejected-request counter

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
op_valid  input  1  controller produced a result this cycle
mode  input  2  mode the controller processed (00 register, 01 vote, 10/11 unused)
ballot_box_id  input  BOX_W  box of the processed userID (userID[5:4])
already_registered  input  1  controller flag
already_voted  input  1  controller flag
not_registered  input  1  controller flag
voting_not_started  input  1  controller flag
registration_ended  input  1  controller flag
election_done  input  1  level; controller has entered its winner phase
report_valid  output  1  summary record available
report_ready  input  1  downstream accepts record
report_box  output  BOX_W  box index of current record
report_regs  output  CNT_W  accepted registrations for report_box
report_votes  output  CNT_W  accepted votes for report_box
report_errors  output  ERR_W  rejected requests for report_box
report_full_turnout  output  1  report_votes == report_regs and report_regs != 0
tally_done  output  1  all NUM_BOXES records accepted

Behaviour:
- Reset (RST_N low, async): all counters 0; state COLLECT; box pointer 0; report_valid 0, report_box 0, report_regs/votes/errors 0, report_full_turnout 0, tally_done 0. Reset mid-report discards everything and restarts in COLLECT.
- FSM states: COLLECT -> REPORT -> DONE. DONE is left only by reset.
- COLLECT, each rising edge with op_valid=1:
  - err = OR of the five flags.
  - mode 00, err=0: regs[ballot_box_id] += 1.
  - mode 01, err=0: votes[ballot_box_id] += 1.
  - mode 00 or 01, err=1: errors[ballot_box_id] += 1.
  - mode 10/11: no counter change, flags ignored.
  - op_valid=0: no change.
- Saturation: every counter saturates at its all-ones value and never wraps.
- Counter update is one-cycle: the count is visible in internal state on the edge after the op. No outputs change in COLLECT.
- COLLECT -> REPORT: on the edge where election_done=1. An op_valid op in that same cycle is still counted before the transition.
- REPORT:
  - report_valid=1.
  - report_box = pointer; report_regs/votes/errors/full_turnout are driven from that box's counters.
  - Outputs must be held stable while report_ready=0.
  - On an edge with report_valid and report_ready both 1: if pointer < NUM_BOXES-1, pointer += 1; else go to DONE.
  - Back-to-back acceptance gives one record per cycle, so the minimum REPORT duration is NUM_BOXES cycles.
  - op_valid and flags are ignored; counters are frozen.
- DONE: report_valid=0; tally_done=1 (registered, asserted the cycle after the last handshake); report_* data outputs hold the last record; op_valid ignored.
- election_done deasserting after COLLECT has no effect.
- report_full_turnout is combinational from the current record fields.

Test Plan:
- Reset, then 3 ops mode 00 box 2 no flags, 1 op mode 01 box 2 no flags, election_done, report_ready=1 -> records box0 (0,0,0,ft=0), box1 (0,0,0,0), box2 (regs 3, votes 1, errors 0, ft=0), box3 zeros on 4 consecutive cycles; tally_done=1 on the next cycle.
- Mixed errors: mode 00 box1 already_registered=1; mode 01 box1 not_registered=1; mode 01 box3 voting_not_started=1; mode 10 box0 no flags -> box1 errors 2, box3 errors 1, box0 all zero.
- Full turnout with stall: 2 regs and 2 votes on box0, election_done, report_ready low for 3 cycles -> report_valid=1 with box0 (2,2,0,ft=1) held stable for all 3 cycles, pointer advances only after ready rises.
- Saturation: 40 accepted registrations on box3 and 300 rejected ops on box3 -> report shows regs 31, errors 255, no wrap.
- Same-cycle close: an op_valid accepted vote on box1 coincident with election_done -> box1 votes 1 in report; an op_valid in the following cycle is not counted.
- Reset mid-report: RST_N low after box1 is accepted -> report_valid 0, counters 0 immediately; state COLLECT after release; a new election_done reports all-zero records.
